// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access
//  Description : MEM-stage load/store unit. Issues single-port data-RAM
//                transactions over a req/ack bus, aligns and sign-extends
//                load data for write-back, and stalls the pipeline while a
//                transaction is outstanding. Non-memory ops pass through.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access #(
    parameter int ACK_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_alu_op_i,
    input  logic [31:0] mem_ramaddr_i,
    input  logic [31:0] mem_store_data_i,
    // Write-back request packed as {en, addr[4:0], data[31:0]}
    input  logic [37:0] mem_wreg_i,
    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    input  logic        ram_ack_i,
    output logic [37:0] mem_wreg_o,
    output logic        stallreq_from_mem,
    output logic        misalign_o,
    output logic        bus_err_o
);

    // ALU op encodings shared with the EX stage
    localparam logic [7:0] c_op_lb = 8'h20;
    localparam logic [7:0] c_op_lw = 8'h23;
    localparam logic [7:0] c_op_sb = 8'h28;
    localparam logic [7:0] c_op_sw = 8'h2B;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;

    localparam logic [TO_W-1:0] c_to_last = TO_W'(ACK_TIMEOUT - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [TO_W-1:0] r_cnt;
    logic [31:0]     r_rdata;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [3:0]      r_sel;
    logic [31:0]     r_wdata;
    logic            r_bus_err;

    logic        w_is_lb, w_is_lw, w_is_sb, w_is_sw;
    logic        w_is_load, w_is_store, w_is_mem, w_is_word;
    logic        w_misalign, w_start, w_timeout;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [31:0] w_load_data;

    assign w_is_lb    = (mem_alu_op_i == c_op_lb);
    assign w_is_lw    = (mem_alu_op_i == c_op_lw);
    assign w_is_sb    = (mem_alu_op_i == c_op_sb);
    assign w_is_sw    = (mem_alu_op_i == c_op_sw);
    assign w_is_load  = w_is_lb | w_is_lw;
    assign w_is_store = w_is_sb | w_is_sw;
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_is_word  = w_is_lw | w_is_sw;

    // Word accesses must be word aligned; byte accesses never trap
    assign w_misalign = w_is_word & (mem_ramaddr_i[1:0] != 2'b00);
    assign w_start    = (r_state == c_st_idle) & w_is_mem & ~w_misalign;
    assign w_timeout  = (r_state == c_st_access) & ~ram_ack_i & (r_cnt == c_to_last);

    // Big-endian lanes: byte offset 0 lives in bits [31:24]
    assign w_sel   = w_is_word ? 4'b1111 : (4'b1000 >> mem_ramaddr_i[1:0]);
    assign w_wdata = w_is_sb ? {4{mem_store_data_i[7:0]}} : mem_store_data_i;

    // Select the addressed byte of the captured word for LB
    always_comb begin
        w_byte = r_rdata[31:24];
        case (mem_ramaddr_i[1:0])
            2'd0:    w_byte = r_rdata[31:24];
            2'd1:    w_byte = r_rdata[23:16];
            2'd2:    w_byte = r_rdata[15:8];
            default: w_byte = r_rdata[7:0];
        endcase
    end

    assign w_load_data = w_is_lw ? r_rdata : {{24{w_byte[7]}}, w_byte};

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_next_state;
    end

    // Next-state logic: DONE always lasts exactly one cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:   if (w_start) w_next_state = c_st_access;
            c_st_access: if (ram_ack_i || w_timeout) w_next_state = c_st_done;
            c_st_done:   w_next_state = c_st_idle;
            default:     w_next_state = c_st_idle;
        endcase
    end

    // Bus latches, timeout counter and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_sel     <= '0;
            r_wdata   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
            if (w_start) begin
                r_we    <= w_is_store;
                r_addr  <= {mem_ramaddr_i[31:2], 2'b00};
                r_sel   <= w_sel;
                r_wdata <= w_wdata;
                r_cnt   <= '0;
            end
            if (r_state == c_st_access) begin
                if (ram_ack_i)      r_rdata <= ram_rdata_i;
                else if (w_timeout) r_rdata <= '0;
                else                r_cnt   <= r_cnt + TO_W'(1);
            end
        end
    end

    assign ram_we_o    = r_we;
    assign ram_addr_o  = r_addr;
    assign ram_sel_o   = r_sel;
    assign ram_wdata_o = r_wdata;

    // Outputs: request, stall, write-back shaping and status pulses
    always_comb begin
        ram_req_o         = 1'b0;
        stallreq_from_mem = 1'b0;
        misalign_o        = 1'b0;
        mem_wreg_o        = mem_wreg_i;
        bus_err_o         = r_bus_err;
        case (r_state)
            c_st_idle: begin
                if (w_is_mem) begin
                    if (w_misalign) begin
                        misalign_o     = 1'b1;
                        mem_wreg_o[37] = 1'b0;
                    end else begin
                        stallreq_from_mem = 1'b1;
                        mem_wreg_o        = '0;
                    end
                end
            end
            c_st_access: begin
                ram_req_o         = 1'b1;
                stallreq_from_mem = 1'b1;
                mem_wreg_o        = '0;
            end
            c_st_done: begin
                if (w_is_load) mem_wreg_o = {mem_wreg_i[37:32], w_load_data};
                else           mem_wreg_o[37] = 1'b0;
            end
            default: mem_wreg_o = '0;
        endcase
        if (rst) begin
            stallreq_from_mem = 1'b0;
            misalign_o        = 1'b0;
            mem_wreg_o        = '0;
            bus_err_o         = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access
//  Description : Directed self-checking bench for mem_access.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    localparam logic [7:0] c_op_nop = 8'h00;
    localparam logic [7:0] c_op_or  = 8'h25;
    localparam logic [7:0] c_op_lb  = 8'h20;
    localparam logic [7:0] c_op_lw  = 8'h23;
    localparam logic [7:0] c_op_sb  = 8'h28;
    localparam logic [7:0] c_op_sw  = 8'h2B;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [37:0] wreg_i;
    logic        req, we;
    logic [31:0] raddr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic [37:0] wreg_o;
    logic        stall, misalign, bus_err;

    int total = 0;
    int bad   = 0;
    int cnt;

    mem_access #(.ACK_TIMEOUT(16), .TO_W(5)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_alu_op_i      (op),
        .mem_ramaddr_i     (addr),
        .mem_store_data_i  (sdata),
        .mem_wreg_i        (wreg_i),
        .ram_req_o         (req),
        .ram_we_o          (we),
        .ram_addr_o        (raddr),
        .ram_sel_o         (sel),
        .ram_wdata_o       (wdata),
        .ram_rdata_i       (rdata),
        .ram_ack_i         (ack),
        .mem_wreg_o        (wreg_o),
        .stallreq_from_mem (stall),
        .misalign_o        (misalign),
        .bus_err_o         (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with a misaligned LW and a live write-back on the inputs
        rst = 1'b1; op = c_op_lw; addr = 32'h302; sdata = '0;
        wreg_i = {1'b1, 5'd3, 32'hFF}; rdata = '0; ack = 1'b0;
        cyc; cyc; #1;
        chk("rst_wreg",     wreg_o, 0);
        chk("rst_stall",    stall, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_req",      req, 0);
        chk("rst_buserr",   bus_err, 0);
        chk("rst_addr",     raddr, 0);
        chk("rst_sel",      sel, 0);

        // Passthrough
        rst = 1'b0; op = c_op_or; addr = 32'h0; wreg_i = {1'b1, 5'd3, 32'h0000_00FF};
        #1;
        chk("pass_wreg",  wreg_o, {1'b1, 5'd3, 32'h0000_00FF});
        chk("pass_stall", stall, 0);
        chk("pass_req",   req, 0);
        cyc; #1;
        chk("pass_req2",  req, 0);

        // LW, ack in first ACCESS cycle
        op = c_op_lw; addr = 32'h100; wreg_i = {1'b1, 5'd7, 32'h0};
        #1;
        chk("lw_stall_det", stall, 1);
        cyc; ack = 1'b1; rdata = 32'hDEAD_BEEF; #1;
        chk("lw_req",   req, 1);
        chk("lw_stall_acc", stall, 1);
        chk("lw_sel",   sel, 4'hF);
        chk("lw_we",    we, 0);
        chk("lw_addr",  raddr, 32'h100);
        cyc; ack = 1'b0; #1;
        chk("lw_req_done",   req, 0);
        chk("lw_stall_done", stall, 0);
        chk("lw_wreg", wreg_o, {1'b1, 5'd7, 32'hDEAD_BEEF});
        cyc; op = c_op_nop; wreg_i = '0; #1;
        chk("lw_idle_stall", stall, 0);

        // LB at offset 2 then offset 3
        op = c_op_lb; addr = 32'h102; wreg_i = {1'b1, 5'd9, 32'h0}; #1;
        chk("lb2_stall", stall, 1);
        cyc; ack = 1'b1; rdata = 32'h1122_8344; #1;
        chk("lb2_sel", sel, 4'b0010);
        cyc; ack = 1'b0; #1;
        chk("lb2_wreg", wreg_o, {1'b1, 5'd9, 32'hFFFF_FF83});
        cyc; addr = 32'h103; #1;
        chk("lb3_stall", stall, 1);
        cyc; ack = 1'b1; #1;
        chk("lb3_sel", sel, 4'b0001);
        cyc; ack = 1'b0; #1;
        chk("lb3_wreg", wreg_o, {1'b1, 5'd9, 32'h0000_0044});
        cyc; op = c_op_nop; wreg_i = '0;

        // SB with three wait cycles before ack
        op = c_op_sb; addr = 32'h201; sdata = 32'h0000_00A5; wreg_i = {1'b1, 5'd4, 32'h1234};
        cnt = 0; #1;
        if (stall) cnt++;
        cyc; #1;
        chk("sb_we",    we, 1);
        chk("sb_sel",   sel, 4'b0100);
        chk("sb_wdata", wdata, 32'hA5A5_A5A5);
        chk("sb_addr",  raddr, 32'h200);
        if (stall) cnt++;
        cyc; #1; if (stall) cnt++;
        cyc; #1; if (stall) cnt++;
        cyc; ack = 1'b1; #1;
        chk("sb_req_ack", req, 1);
        if (stall) cnt++;
        cyc; ack = 1'b0; #1;
        if (stall) cnt++;
        chk("sb_stall_cycles", cnt, 5);
        chk("sb_wreg_en", wreg_o[37], 0);
        chk("sb_req_done", req, 0);
        // Stray ack while idle must not start anything
        cyc; op = c_op_nop; wreg_i = '0; ack = 1'b1;
        cyc; ack = 1'b0; #1;
        chk("stray_ack_req", req, 0);

        // Misaligned SW
        op = c_op_sw; addr = 32'h302; wreg_i = {1'b1, 5'd2, 32'h5}; #1;
        chk("mis_pulse", misalign, 1);
        chk("mis_stall", stall, 0);
        chk("mis_en",    wreg_o[37], 0);
        cyc; #1;
        chk("mis_req", req, 0);
        op = c_op_nop; wreg_i = '0; #1;
        chk("mis_end", misalign, 0);

        // Timeout: ack never arrives
        op = c_op_lw; addr = 32'h400; wreg_i = {1'b1, 5'd11, 32'hCAFE}; #1;
        chk("to_stall", stall, 1);
        cyc;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!req) break;
            cnt++;
            chk("to_buserr_early", bus_err, 0);
            cyc;
        end
        chk("to_req_cycles", cnt, 16);
        chk("to_buserr", bus_err, 1);
        chk("to_wreg",   wreg_o, {1'b1, 5'd11, 32'h0});
        cyc; op = c_op_nop; wreg_i = '0; #1;
        chk("to_buserr_end", bus_err, 0);

        // Reset during ACCESS
        op = c_op_lw; addr = 32'h500; wreg_i = {1'b1, 5'd12, 32'h77};
        cyc; #1;
        chk("rsta_req", req, 1);
        rst = 1'b1; #1;
        chk("rsta_wreg",  wreg_o, 0);
        chk("rsta_stall", stall, 0);
        cyc; #1;
        chk("rsta_req_next", req, 0);
        chk("rsta_addr", raddr, 0);
        rst = 1'b0; op = c_op_nop; wreg_i = '0; #1;
        chk("rsta_en", wreg_o[37], 0);
        cyc; #1;
        chk("rsta_idle_req", req, 0);
        chk("rsta_idle_stall", stall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM-stage load/store unit. Consumes the RAM address, ALU op, store operand and write-back request produced by the EX stage.
- Drives a single-port data-RAM bus using a req/ack handshake.
- Returns aligned, sign-extended load data to the write-back path.
- Stalls the pipeline while a RAM transaction is outstanding. All non-memory ops pass straight through.

Parameters:
- ACK_TIMEOUT, 16: maximum cycles in ACCESS waiting for ram_ack_i before the transaction is aborted.
- TO_W, 5: width of the timeout counter. Must satisfy 2^TO_W > ACK_TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset (RST_ENABLE = 1).
- mem_alu_op_i  in  alu_t.op width  ALU op from EX (LB_OP, LW_OP, SB_OP, SW_OP, others).
- mem_ramaddr_i  in  32  effective address from EX.
- mem_store_data_i  in  32  store operand (rt value).
- mem_wreg_i  in  reg_t  write-back request from EX (en, addr[4:0], data[31:0]).
- ram_req_o  out  1  bus request, held until ack or timeout.
- ram_we_o  out  1  1 = store, 0 = load.
- ram_addr_o  out  32  word address; bits [1:0] forced to 0.
- ram_sel_o  out  4  byte enables; bit 3 = bits [31:24].
- ram_wdata_o  out  32  store data.
- ram_rdata_i  in  32  load data, valid in the ack cycle.
- ram_ack_i  in  1  transaction complete.
- mem_wreg_o  out  reg_t  write-back request to WB.
- stallreq_from_mem  out  1  pipeline stall request.
- misalign_o  out  1  one-cycle pulse on a misaligned LW or SW.
- bus_err_o  out  1  one-cycle pulse on timeout.

Behaviour:
- Byte order is big-endian: byte offset 0 maps to bits [31:24].
- States: IDLE, ACCESS, DONE. Reset returns to IDLE and clears the captured data, the timeout counter and all registered bus outputs. While rst = 1, mem_wreg_o = 0, stallreq_from_mem = 0, misalign_o = 0, bus_err_o = 0.
- IDLE, non-memory op:
  - mem_wreg_o = mem_wreg_i (combinational).
  - stallreq_from_mem = 0.
  - No bus activity.
- IDLE, LW/SW with addr[1:0] != 0:
  - misalign_o = 1 this cycle.
  - mem_wreg_o.en = 0; no stall; no bus access; stay in IDLE.
- IDLE, valid memory op:
  - stallreq_from_mem = 1 combinationally.
  - Latch the following: ram_we_o, ram_addr_o = {addr[31:2], 2'b00}, ram_sel_o and ram_wdata_o.
  - Go to ACCESS and clear the counter.
- Lane rules:
  - LW/SW: sel = 4'b1111, wdata = store data.
  - LB/SB: sel = 4'b1000 >> addr[1:0]; SB wdata = store byte [7:0] replicated into all four lanes.
- ACCESS:
  - ram_req_o = 1, stallreq_from_mem = 1.
  - If ram_ack_i = 1, capture ram_rdata_i and go to DONE. Ack is legal in the first ACCESS cycle.
  - Otherwise increment the counter.
  - When the counter reaches ACK_TIMEOUT-1 with no ack, pulse bus_err_o, capture 0 and go to DONE.
- DONE:
  - ram_req_o = 0, stallreq_from_mem = 0.
  - Load: mem_wreg_o = {mem_wreg_i.en, mem_wreg_i.addr, result}. LW result = captured word. LB result = selected byte sign-extended to 32 bits.
  - Store: mem_wreg_o.en = 0.
  - Next cycle goes to IDLE unconditionally.
- Timing: minimum load/store occupancy is 3 cycles (detect, ACCESS with ack, DONE). EX inputs are held stable by the stall until the DONE cycle ends.
- Bus discipline:
  - ram_req_o falls in the cycle after ack. No new request may be issued in DONE.
  - ram_ack_i outside ACCESS is ignored.
- Reset in mid-ACCESS drops ram_req_o in the next cycle. The pending transaction is abandoned with no write-back.
- Bus outputs hold their last values when ram_req_o = 0; only ram_req_o is qualifying.

Test Plan:
- Passthrough: OR_OP with wreg {1, 5'd3, 32'h0000_00FF} -> mem_wreg_o identical in the same cycle; stall 0; ram_req_o stays 0.
- LW: addr 0x100, ack in the first ACCESS cycle with rdata 0xDEADBEEF -> stall high for 2 cycles; ram_sel_o = 4'hF, ram_we_o = 0; in DONE, mem_wreg_o.data = 0xDEADBEEF.
- LB sign-extend: addr 0x102, rdata 0x1122_8344 -> ram_sel_o = 4'b0010; result 0xFFFF_FF83. Repeat at addr 0x103 -> 0x0000_0044.
- SB: addr 0x201, store data 0x0000_00A5, ack after 3 wait cycles -> ram_we_o = 1, ram_sel_o = 4'b0100, ram_wdata_o = 0xA5A5A5A5; stall for 5 cycles; mem_wreg_o.en = 0.
- Misaligned SW at 0x302 -> misalign_o = 1 for one cycle; ram_req_o never asserts; no stall.
- Timeout: LW with ack never asserted, ACK_TIMEOUT = 16 -> ram_req_o high for 16 cycles, then bus_err_o pulses; DONE writes 0. Separately, assert rst during ACCESS -> ram_req_o = 0 the next cycle; state IDLE; no write-back.
